// File: rtl/ysyx_23060191_ifu_pkg.sv
// Shared constants and state encoding for the instruction fetch unit.
package ysyx_23060191_ifu_pkg;

    localparam int          DEF_CPU_WIDTH = 32;
    localparam logic [31:0] DEF_RESET_PC  = 32'h8000_0000;
    localparam logic [31:0] DEF_NOP_INST  = 32'h0000_0013;

    typedef enum logic [1:0] {
        ST_REQ  = 2'd0,
        ST_WAIT = 2'd1,
        ST_HOLD = 2'd2
    } ifu_state_e;

endpackage

// File: rtl/ysyx_23060191_Reg.sv
// Generic register with synchronous active-high reset and write enable.
module ysyx_23060191_Reg #(
    parameter int               WIDTH     = 1,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             wen,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout
);

    // storage: reset wins, otherwise load on write enable
    always_ff @(posedge clk) begin
        if (rst) begin
            dout <= RESET_VAL;
        end else if (wen) begin
            dout <= din;
        end
    end

endmodule

// File: rtl/ysyx_23060191_ifu.sv
// Instruction fetch unit: owns the PC, issues one fetch at a time and
// presents each fetched word to the decoder over a valid/ready handshake.
module ysyx_23060191_ifu
    import ysyx_23060191_ifu_pkg::*;
#(
    parameter int                   CPU_WIDTH = DEF_CPU_WIDTH,
    parameter logic [CPU_WIDTH-1:0] RESET_PC  = CPU_WIDTH'(DEF_RESET_PC)
) (
    input  logic                 clk,
    input  logic                 rst,
    output logic                 imem_req_valid,
    input  logic                 imem_req_ready,
    output logic [CPU_WIDTH-1:0] imem_req_addr,
    input  logic                 imem_resp_valid,
    input  logic [CPU_WIDTH-1:0] imem_resp_data,
    input  logic                 imem_resp_err,
    input  logic                 redirect_valid,
    input  logic [CPU_WIDTH-1:0] redirect_pc,
    output logic                 inst_valid,
    input  logic                 inst_ready,
    output logic [CPU_WIDTH-1:0] inst,
    output logic [CPU_WIDTH-1:0] pc,
    output logic                 inst_err
);

    localparam int OUT_W = 2 * CPU_WIDTH + 1;

    ifu_state_e           state_q, state_d;
    logic                 kill_q, kill_d;
    logic                 fetch_pc_we_s;
    logic [CPU_WIDTH-1:0] fetch_pc_q, fetch_pc_d;
    logic [CPU_WIDTH-1:0] target_s;
    logic                 out_we_s;
    logic [OUT_W-1:0]     out_d, out_q;

    assign target_s = redirect_pc & ~CPU_WIDTH'(3);

    // next-state, PC update and output-register load decisions
    always_comb begin
        state_d       = state_q;
        kill_d        = kill_q;
        fetch_pc_we_s = 1'b0;
        fetch_pc_d    = fetch_pc_q;
        out_we_s      = 1'b0;
        out_d = {(imem_resp_err ? CPU_WIDTH'(DEF_NOP_INST) : imem_resp_data),
                 fetch_pc_q, imem_resp_err};
        case (state_q)
            ST_REQ: begin
                if (redirect_valid) begin
                    fetch_pc_we_s = 1'b1;
                    fetch_pc_d    = target_s;
                end else begin
                    fetch_pc_we_s = 1'b0;
                end
                // a request accepted alongside a redirect fetches the old PC
                if (imem_req_ready) begin
                    state_d = ST_WAIT;
                    kill_d  = redirect_valid;
                end else begin
                    state_d = ST_REQ;
                end
            end
            ST_WAIT: begin
                if (redirect_valid) begin
                    fetch_pc_we_s = 1'b1;
                    fetch_pc_d    = target_s;
                    if (imem_resp_valid) begin
                        kill_d  = 1'b0;
                        state_d = ST_REQ;
                    end else begin
                        kill_d  = 1'b1;
                    end
                end else if (imem_resp_valid) begin
                    if (kill_q) begin
                        kill_d  = 1'b0;
                        state_d = ST_REQ;
                    end else begin
                        out_we_s = 1'b1;
                        state_d  = ST_HOLD;
                    end
                end else begin
                    state_d = ST_WAIT;
                end
            end
            ST_HOLD: begin
                // redirect replaces the sequential +4 even if the word was taken
                if (redirect_valid) begin
                    fetch_pc_we_s = 1'b1;
                    fetch_pc_d    = target_s;
                    state_d       = ST_REQ;
                end else if (inst_ready) begin
                    fetch_pc_we_s = 1'b1;
                    fetch_pc_d    = fetch_pc_q + CPU_WIDTH'(4);
                    state_d       = ST_REQ;
                end else begin
                    state_d = ST_HOLD;
                end
            end
            default: begin
                state_d = ST_REQ;
                kill_d  = 1'b0;
            end
        endcase
    end

    // FSM state and kill flag
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_REQ;
            kill_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            kill_q  <= kill_d;
        end
    end

    ysyx_23060191_Reg #(
        .WIDTH     (CPU_WIDTH),
        .RESET_VAL (RESET_PC)
    ) u_fetch_pc (
        .clk  (clk),
        .rst  (rst),
        .wen  (fetch_pc_we_s),
        .din  (fetch_pc_d),
        .dout (fetch_pc_q)
    );

    ysyx_23060191_Reg #(
        .WIDTH     (OUT_W),
        .RESET_VAL ({CPU_WIDTH'(0), RESET_PC, 1'b0})
    ) u_out (
        .clk  (clk),
        .rst  (rst),
        .wen  (out_we_s),
        .din  (out_d),
        .dout (out_q)
    );

    // handshake valids are silenced while reset is asserted
    assign imem_req_valid = (state_q == ST_REQ) && !rst;
    assign inst_valid     = (state_q == ST_HOLD) && !rst;
    assign imem_req_addr  = fetch_pc_q;
    assign inst           = out_q[OUT_W-1 -: CPU_WIDTH];
    assign pc             = out_q[CPU_WIDTH:1];
    assign inst_err       = out_q[0];

endmodule

// File: tb/tb_ysyx_23060191_ifu.sv
// Self-checking bench: transaction-level model of the expected fetch stream.
module tb_ysyx_23060191_ifu;

    localparam logic [31:0] RPC = 32'h8000_0000;
    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        imem_req_valid;
    logic        imem_req_ready = 1'b0;
    logic [31:0] imem_req_addr;
    logic        imem_resp_valid = 1'b0;
    logic [31:0] imem_resp_data = 32'h0;
    logic        imem_resp_err = 1'b0;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc = 32'h0;
    logic        inst_valid;
    logic        inst_ready = 1'b0;
    logic [31:0] inst;
    logic [31:0] pc;
    logic        inst_err;

    int          checks = 0;
    int          errors = 0;
    int          cyc = 0;
    int          hold_cyc = 0;
    logic [31:0] exp_pc;

    ysyx_23060191_ifu dut (
        .clk             (clk),
        .rst             (rst),
        .imem_req_valid  (imem_req_valid),
        .imem_req_ready  (imem_req_ready),
        .imem_req_addr   (imem_req_addr),
        .imem_resp_valid (imem_resp_valid),
        .imem_resp_data  (imem_resp_data),
        .imem_resp_err   (imem_resp_err),
        .redirect_valid  (redirect_valid),
        .redirect_pc     (redirect_pc),
        .inst_valid      (inst_valid),
        .inst_ready      (inst_ready),
        .inst            (inst),
        .pc              (pc),
        .inst_err        (inst_err)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return a ^ 32'hFFFF_FFFF;
    endfunction

    task automatic step();
        @(negedge clk);
    endtask

    task automatic wait_req(output bit ok);
        int n = 0;
        while (imem_req_valid !== 1'b1 && n < 20) begin
            step();
            n++;
        end
        ok = (imem_req_valid === 1'b1);
        if (!ok) check("req_timeout", 64'(imem_req_valid), 64'd1);
    endtask

    // modes: 0 normal, 1 access fault, 2 redirect in idle REQ, 3 redirect with
    // request handshake, 4 redirect in WAIT, 5 redirect in HOLD, 6 reset in WAIT
    task automatic txn(input int mode, input int s, input int d, input int h,
                       input logic [31:0] tgt, input bit rr);
        bit          ok;
        int          k;
        logic [31:0] a;
        logic [31:0] exp_inst;
        bit          e;
        e = (mode == 1);
        k = $urandom_range(0, d);
        wait_req(ok);
        if (!ok) return;
        check("req_addr", 64'(imem_req_addr), 64'(exp_pc));
        a = imem_req_addr;
        if (mode == 2) begin
            redirect_valid = 1'b1;
            redirect_pc    = tgt;
            step();
            redirect_valid = 1'b0;
            exp_pc = tgt & ~32'h3;
            check("redir_idle_valid", 64'(imem_req_valid), 64'd1);
            check("redir_idle_addr", 64'(imem_req_addr), 64'(exp_pc));
            return;
        end
        for (int i = 0; i < s; i++) begin
            step();
            check("req_stall", {31'd0, imem_req_valid, imem_req_addr}, {31'd0, 1'b1, a});
        end
        imem_req_ready = 1'b1;
        if (mode == 3) begin
            redirect_valid = 1'b1;
            redirect_pc    = tgt;
        end
        step();
        imem_req_ready = 1'b0;
        redirect_valid = 1'b0;
        if (mode == 3) exp_pc = tgt & ~32'h3;
        for (int i = 0; i <= d; i++) begin
            check("wait_quiet", 64'({imem_req_valid, inst_valid}), 64'd0);
            if (i == d) begin
                imem_resp_valid = 1'b1;
                imem_resp_data  = mem_word(a);
                imem_resp_err   = e;
            end
            if (mode == 4 && i == k) begin
                redirect_valid = 1'b1;
                redirect_pc    = tgt;
            end
            if (mode == 6 && i == k) rst = 1'b1;
            step();
            imem_resp_valid = 1'b0;
            imem_resp_err   = 1'b0;
            redirect_valid  = 1'b0;
            if (mode == 6 && i == k) begin
                rst = 1'b0;
                break;
            end
        end
        if (mode == 4) exp_pc = tgt & ~32'h3;
        if (mode == 6) begin
            #1;
            exp_pc = RPC;
            check("rst_req", {31'd0, imem_req_valid, imem_req_addr}, {31'd0, 1'b1, RPC});
            check("rst_outs", {inst_valid, inst_err, 30'd0, pc}, {1'b0, 1'b0, 30'd0, RPC});
            imem_resp_valid = 1'b1;
            imem_resp_data  = mem_word(a);
            step();
            imem_resp_valid = 1'b0;
            check("late_resp_ignored", 64'({imem_req_valid, inst_valid}), 64'd2);
            return;
        end
        if (mode == 3 || mode == 4) begin
            check("stale_dropped", 64'({imem_req_valid, inst_valid}), 64'd2);
            check("redir_addr", 64'(imem_req_addr), 64'(exp_pc));
            return;
        end
        exp_inst = e ? NOP : mem_word(a);
        hold_cyc = cyc;
        for (int i = 0; i <= h; i++) begin
            check("hold_ctl", 64'({inst_valid, imem_req_valid, inst_err}), 64'({1'b1, 1'b0, e}));
            check("hold_inst", 64'(inst), 64'(exp_inst));
            check("hold_pc", 64'(pc), 64'(a));
            if (i == h) begin
                inst_ready = 1'b1;
                if (mode == 5) begin
                    redirect_valid = 1'b1;
                    redirect_pc    = tgt;
                    inst_ready     = rr;
                end
            end
            step();
            inst_ready     = 1'b0;
            redirect_valid = 1'b0;
        end
        exp_pc = (mode == 5) ? (tgt & ~32'h3) : (a + 32'd4);
        check("after_hold", 64'({inst_valid, imem_req_valid}), 64'd1);
        check("next_addr", 64'(imem_req_addr), 64'(exp_pc));
    endtask

    initial begin
        int prev;
        int mode;
        step();
        step();
        check("rst_cycle_valids", 64'({imem_req_valid, inst_valid}), 64'd0);
        rst = 1'b0;
        #1;
        check("rst_release", {imem_req_valid, inst_valid, inst_err, inst, pc[28:0]},
              {1'b1, 1'b0, 1'b0, 32'd0, RPC[28:0]});
        check("rst_pc", 64'(pc), 64'(RPC));
        exp_pc = RPC;

        txn(0, 0, 0, 0, 32'h0, 1'b0);
        prev = hold_cyc;
        txn(0, 0, 0, 0, 32'h0, 1'b0);
        check("throughput1", 64'(hold_cyc - prev), 64'd3);
        prev = hold_cyc;
        txn(0, 0, 0, 0, 32'h0, 1'b0);
        check("throughput2", 64'(hold_cyc - prev), 64'd3);

        txn(0, 4, 3, 1, 32'h0, 1'b0);
        txn(4, 1, 2, 0, 32'h8000_0103, 1'b0);
        txn(5, 0, 0, 1, 32'h8000_0100, 1'b1);
        txn(1, 0, 1, 0, 32'h0, 1'b0);
        txn(0, 0, 0, 0, 32'h0, 1'b0);
        txn(6, 0, 2, 0, 32'h0, 1'b0);
        txn(0, 0, 0, 0, 32'h0, 1'b0);
        txn(3, 0, 1, 0, 32'h8000_0207, 1'b0);
        txn(0, 0, 0, 0, 32'h0, 1'b0);
        txn(2, 0, 0, 0, 32'hFFFF_FFFE, 1'b0);
        txn(0, 0, 0, 0, 32'h0, 1'b0);
        txn(0, 0, 0, 0, 32'h0, 1'b0);

        for (int n = 0; n < 80; n++) begin
            mode = $urandom_range(0, 6);
            txn(mode, $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 2),
                32'h8000_0000 | 32'($urandom_range(0, 4095)), 1'($urandom_range(0, 1)));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #300000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
